// File: rtl/prco_mem_arbiter_pkg.sv
// prco_mem_arbiter_pkg: state/owner encodings and helpers for the local-memory arbiter
package prco_mem_arbiter_pkg;
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_RESP  = 2'd3;
  localparam logic ARB_OWN_IF = 1'b0;
  localparam logic ARB_OWN_LS = 1'b1;
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction
endpackage

// File: rtl/prco_mem_arbiter.sv
// prco_mem_arbiter: shares the single-ported local memory between fetch and load/store
module prco_mem_arbiter
  import prco_mem_arbiter_pkg::*;
#(
  parameter int P_ADDR_WIDTH  = 16,
  parameter int P_DATA_WIDTH  = 16,
  parameter int P_MEM_LATENCY = 1,
  parameter int P_LS_RUN_MAX  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_if_req,
  input  logic [P_ADDR_WIDTH-1:0] i_if_addr,
  input  logic                    i_if_flush,
  output logic                    q_if_gnt,
  output logic                    q_if_valid,
  output logic [P_DATA_WIDTH-1:0] q_if_data,
  input  logic                    i_ls_req,
  input  logic                    i_ls_we,
  input  logic [P_ADDR_WIDTH-1:0] i_ls_addr,
  input  logic [P_DATA_WIDTH-1:0] i_ls_wdata,
  output logic                    q_ls_gnt,
  output logic                    q_ls_valid,
  output logic [P_DATA_WIDTH-1:0] q_ls_rdata,
  output logic                    q_mem_ce_fetch,
  output logic                    q_mem_ce_alu,
  output logic                    q_mem_we,
  output logic [P_ADDR_WIDTH-1:0] q_mem_addr,
  output logic [P_DATA_WIDTH-1:0] q_mem_dina,
  input  logic [P_DATA_WIDTH-1:0] i_mem_douta,
  output logic                    q_busy
);
  localparam logic [3:0] RUN_MAX  = 4'(P_LS_RUN_MAX);
  localparam logic [2:0] LAT_WAIT = 3'(P_MEM_LATENCY - 1);
  logic [1:0]              st;
  logic                    own, we_q, flushed;
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic [P_DATA_WIDTH-1:0] dina_q, if_data_q, ls_data_q;
  logic [2:0]              lat_cnt;
  logic [3:0]              ls_run;
  logic                    arb, any_req, if_win, issue, resp, if_done, ls_done, flush_hit;
  always_comb begin
    arb       = st == ARB_IDLE || st == ARB_RESP;
    issue     = st == ARB_ISSUE;
    resp      = st == ARB_RESP;
    any_req   = i_if_req | i_ls_req;
    if_win    = i_if_req && (!i_ls_req || ls_run == RUN_MAX);
    flush_hit = i_if_flush && own == ARB_OWN_IF;
    if_done   = resp && own == ARB_OWN_IF && !flushed && !i_if_flush;
    ls_done   = resp && own == ARB_OWN_LS;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st        <= ARB_IDLE;
      own       <= ARB_OWN_IF;
      we_q      <= 1'b0;
      flushed   <= 1'b0;
      addr_q    <= '0;
      dina_q    <= '0;
      if_data_q <= '0;
      ls_data_q <= '0;
      lat_cnt   <= '0;
      ls_run    <= '0;
    end else begin
      if (if_done) if_data_q <= i_mem_douta;
      if (ls_done) ls_data_q <= i_mem_douta;
      if (arb) begin
        st     <= any_req ? ARB_ISSUE : ARB_IDLE;
        ls_run <= (!i_if_req || if_win) ? 4'd0 : sat_inc(ls_run, RUN_MAX);
        if (any_req) begin
          own     <= if_win ? ARB_OWN_IF : ARB_OWN_LS;
          addr_q  <= if_win ? i_if_addr : i_ls_addr;
          we_q    <= !if_win && i_ls_we;
          dina_q  <= if_win ? '0 : i_ls_wdata;
          flushed <= 1'b0;
        end
      end else begin
        // a flush seen before RESP is remembered so the response is dropped
        flushed <= flushed | flush_hit;
        lat_cnt <= issue ? LAT_WAIT : lat_cnt - 3'd1;
        st      <= (issue ? LAT_WAIT == 3'd0 : lat_cnt == 3'd1) ? ARB_RESP : ARB_WAIT;
      end
    end
  end
  assign q_if_gnt       = issue && own == ARB_OWN_IF;
  assign q_ls_gnt       = issue && own == ARB_OWN_LS;
  assign q_mem_ce_fetch = q_if_gnt;
  assign q_mem_ce_alu   = q_ls_gnt;
  assign q_mem_we       = issue && we_q;
  assign q_mem_addr     = addr_q;
  assign q_mem_dina     = dina_q;
  assign q_if_valid     = if_done;
  assign q_ls_valid     = ls_done;
  // the RESP cycle forwards memory data so it lines up with its valid pulse
  assign q_if_data      = if_done ? i_mem_douta : if_data_q;
  assign q_ls_rdata     = ls_done ? i_mem_douta : ls_data_q;
  assign q_busy         = st != ARB_IDLE;
endmodule
